fp16_norm_round_pack: RTL and testbench
=======================================

// Module: fp16_norm_round_pack
// PURPOSE
//   Sequential stage directly downstream of the half-precision multiplier datapath. It takes the
//   raw 22-bit mantissa product and the biased exponent sum, then normalises, rounds
//   (round-to-nearest-even) and packs the result into an IEEE-754 binary16 word.
//   Overflow saturates to infinity and underflow flushes to zero. Uses a valid/ready handshake
//   on both sides.
// PARAMETERS
//   EXP_W  5   exponent field width
//   MAN_W  10  stored fraction width; product width PW = 2*(MAN_W+1) = 22
//   BIAS   15  exponent bias
// PORTS
//   clk        in   1          rising-edge clock
//   rst_n      in   1          asynchronous, active-low reset
//   in_valid   in   1          input operands valid
//   in_ready   out  1          stage can accept (1 only in IDLE)
//   in_sign    in   1          result sign (XOR of operand signs)
//   in_zero    in   1          either operand is zero/subnormal -> force signed zero
//   in_exp_sum in   EXP_W+2    ea+eb, both biased (0..60)
//   in_prod    in   PW         {1,fa}*{1,fb}, range [2^20, 2^22)
//   out_valid  out  1          result valid
//   out_ready  in   1          consumer accepts result
//   out_fp     out  16         packed {sign, exp[4:0], frac[9:0]}
//   out_ovf    out  1          result saturated to infinity
//   out_unf    out  1          result flushed to zero
// BEHAVIOUR
//   Reset: state=IDLE; in_ready=1; out_valid=0; out_fp=0; out_ovf=0; out_unf=0; internal regs=0.
//   FSM: IDLE -> NORM -> ROUND -> DONE -> IDLE. Each state lasts one cycle, except DONE, which holds.
//   IDLE:  in_ready=1. On in_valid, register sign, zero, exp_sum and prod; go to NORM.
//   NORM:  compute e = exp_sum - BIAS as a signed 8-bit value.
//          If prod[21]: m=prod[20:11], g=prod[10], s=|prod[9:0], e=e+1.
//          Else:        m=prod[19:10], g=prod[9],  s=|prod[8:0].
//   ROUND: RNE: if g & (s | m[0]), then m=m+1.
//          If m overflows (was 0x3FF): m=0, e=e+1.
//          Then apply the result rules below and load out_* registers.
//   Result rules, in priority order:
//          zero flag        -> {sign,15'h0}, no flag.
//          e >= 31          -> {sign,5'h1F,10'h0}, out_ovf=1.
//          e <= 0           -> {sign,15'h0}, out_unf=1.
//          otherwise        -> {sign,e[4:0],m}.
//   DONE:  out_valid=1. out_* stay stable until out_ready=1; on out_ready go to IDLE.
//          out_valid drops on that same edge. out_fp, out_ovf and out_unf keep their values until
//          the next load.
//   Latency: out_valid rises on the 2nd rising edge after the accepting edge.
//            Throughput is one result per 4 cycles minimum.
//   In NORM/ROUND/DONE, in_ready=0 and in_valid is ignored; no input is accepted while busy.
//   DONE with out_ready=1 and in_valid=1 in the same cycle: output retires, input is not taken,
//   and the input is accepted on the next IDLE cycle.
//   rst_n low at any point, mid-operation included: immediate return to reset values.
//   The in-flight result is discarded.
//   Exponent arithmetic uses signed 8 bits (range -15..47), so no wrap is possible.
// TESTING
//   1) exp_sum=30, prod=0x100000, sign=0, out_ready=1 -> out_fp=0x3C00, ovf=unf=0,
//      out_valid on 2nd edge after accept.
//   2) exp_sum=30, prod=0x240000 (1.5*1.5) -> 0x4080.
//      Same input with sign=1 -> 0xC080.
//   3) Rounding carry: exp_sum=30, prod=0x3FFFFF -> 0x4400.
//      RNE tie: prod=0x100200 -> 0x3C00 (stays even); prod=0x100600 -> 0x3C02 (rounds up).
//   4) exp_sum=60, prod=0x100000 -> 0x7C00, out_ovf=1.
//      exp_sum=10 -> 0x0000, out_unf=1.
//      in_zero=1 with sign=1 -> 0x8000, no flags.
//   5) Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid=1 and out_fp constant,
//      in_ready=0 throughout; next input accepted only after the handshake.
//   6) Assert rst_n=0 during ROUND -> out_valid=0, in_ready=1 immediately.
//      After release, a new input (exp_sum=30, prod=0x100000) yields 0x3C00.

Source files
------------

// File: rtl/fp16_norm_round_pack.sv
// rtl/fp16_norm_round_pack.sv - normalise, RNE-round and pack a binary16 multiplier product
// Four-state pipeline: IDLE captures, NORM aligns, ROUND rounds and packs, DONE holds for the consumer.
module fp16_norm_round_pack #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10,
  parameter int BIAS  = 15
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_sign,
  input  logic                       in_zero,
  input  logic [EXP_W+1:0]           in_exp_sum,
  input  logic [2*(MAN_W+1)-1:0]     in_prod,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [EXP_W+MAN_W:0]       out_fp,
  output logic                       out_ovf,
  output logic                       out_unf
);

  localparam int PW = 2 * (MAN_W + 1);
  localparam int FW = EXP_W + MAN_W + 1;
  localparam logic signed [7:0] BIAS_S = 8'(BIAS);
  localparam logic signed [7:0] EMAX   = 8'((1 << EXP_W) - 1);

  typedef enum logic [1:0] {S_IDLE, S_NORM, S_ROUND, S_DONE} state_t;

  state_t r_state, w_state_nxt;

  logic                    r_sign, r_zero;
  logic [EXP_W+1:0]        r_exp_sum;
  logic [PW-1:0]           r_prod;
  logic signed [7:0]       r_e;
  logic [MAN_W-1:0]        r_m;
  logic                    r_g, r_s;
  logic [FW-1:0]           r_out_fp;
  logic                    r_out_ovf, r_out_unf;

  logic signed [7:0]       w_e_base, w_e_norm, w_e_rnd;
  logic [MAN_W-1:0]        w_m_norm, w_m_rnd;
  logic                    w_g_norm, w_s_norm, w_rnd_up;
  logic [MAN_W:0]          w_m_sum;
  logic [FW-1:0]           w_fp;
  logic                    w_ovf, w_unf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_state_nxt = S_NORM;
      S_NORM:  w_state_nxt = S_ROUND;
      S_ROUND: w_state_nxt = S_DONE;
      S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign out_fp    = r_out_fp;
  assign out_ovf   = r_out_ovf;
  assign out_unf   = r_out_unf;

  // A product at or above 2^(PW-1) carries one extra integer bit, so shift one further.
  always_comb begin
    w_e_base = signed'(8'(r_exp_sum)) - BIAS_S;
    if (r_prod[PW-1]) begin
      w_m_norm = r_prod[PW-2 -: MAN_W];
      w_g_norm = r_prod[PW-2-MAN_W];
      w_s_norm = |r_prod[PW-3-MAN_W:0];
      w_e_norm = w_e_base + 8'sd1;
    end else begin
      w_m_norm = r_prod[PW-3 -: MAN_W];
      w_g_norm = r_prod[PW-3-MAN_W];
      w_s_norm = |r_prod[PW-4-MAN_W:0];
      w_e_norm = w_e_base;
    end
  end

  // Mantissa carry-out wraps the field to zero and bumps the exponent.
  always_comb begin
    w_rnd_up = r_g & (r_s | r_m[0]);
    w_m_sum  = {1'b0, r_m} + {{MAN_W{1'b0}}, w_rnd_up};
    w_m_rnd  = w_m_sum[MAN_W-1:0];
    w_e_rnd  = w_m_sum[MAN_W] ? (r_e + 8'sd1) : r_e;
    w_fp     = {r_sign, w_e_rnd[EXP_W-1:0], w_m_rnd};
    w_ovf    = 1'b0;
    w_unf    = 1'b0;
    if (r_zero) begin
      w_fp = {r_sign, {(FW-1){1'b0}}};
    end else if (w_e_rnd >= EMAX) begin
      w_fp  = {r_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      w_ovf = 1'b1;
    end else if (w_e_rnd <= 8'sd0) begin
      w_fp  = {r_sign, {(FW-1){1'b0}}};
      w_unf = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sign    <= 1'b0;
      r_zero    <= 1'b0;
      r_exp_sum <= '0;
      r_prod    <= '0;
      r_e       <= '0;
      r_m       <= '0;
      r_g       <= 1'b0;
      r_s       <= 1'b0;
      r_out_fp  <= '0;
      r_out_ovf <= 1'b0;
      r_out_unf <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_sign    <= in_sign;
            r_zero    <= in_zero;
            r_exp_sum <= in_exp_sum;
            r_prod    <= in_prod;
          end
        end
        S_NORM: begin
          r_e <= w_e_norm;
          r_m <= w_m_norm;
          r_g <= w_g_norm;
          r_s <= w_s_norm;
        end
        S_ROUND: begin
          r_out_fp  <= w_fp;
          r_out_ovf <= w_ovf;
          r_out_unf <= w_unf;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp16_norm_round_pack.sv
// tb/tb_fp16_norm_round_pack.sv - scoreboard bench for fp16_norm_round_pack
module tb_fp16_norm_round_pack;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_sign, in_zero;
  logic [6:0]  in_exp_sum;
  logic [21:0] in_prod;
  logic        out_valid, out_ready;
  logic [15:0] out_fp;
  logic        out_ovf, out_unf;

  int total = 0;
  int bad   = 0;
  logic [17:0] sb[$];

  fp16_norm_round_pack dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_sign(in_sign), .in_zero(in_zero),
    .in_exp_sum(in_exp_sum), .in_prod(in_prod),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_fp(out_fp), .out_ovf(out_ovf), .out_unf(out_unf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_output: got fp=0x%04h ovf=%0b unf=%0b want nothing", out_fp, out_ovf, out_unf);
      end else begin
        logic [17:0] e;
        e = sb.pop_front();
        if ({out_fp, out_ovf, out_unf} !== e) begin
          bad++;
          $display("FAIL result: got fp=0x%04h ovf=%0b unf=%0b want fp=0x%04h ovf=%0b unf=%0b",
                   out_fp, out_ovf, out_unf, e[17:2], e[1], e[0]);
        end
      end
    end
  end

  // Called at posedge+1; returns at accepting posedge+1 with in_valid dropped.
  task automatic send(input logic s, input logic z, input logic [6:0] es, input logic [21:0] p,
                      input logic [15:0] efp, input logic eo, input logic eu);
    int n;
    n = 0;
    in_sign = s; in_zero = z; in_exp_sum = es; in_prod = p; in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) begin
      total++; bad++;
      $display("FAIL send_timeout: got in_ready=0 want 1");
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      sb.push_back({efp, eo, eu});
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb.size() != 0) begin
      total++; bad++;
      $display("FAIL drain_timeout: got pending=%0d want 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_sign = 1'b0; in_zero = 1'b0;
    in_exp_sum = '0; in_prod = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_fp", 32'(out_fp), 32'd0);
    chk("rst_ovf", 32'(out_ovf), 32'd0);
    chk("rst_unf", 32'(out_unf), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    send(0, 0, 7'd30, 22'h100000, 16'h3C00, 0, 0);
    chk("lat_edge0_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk("lat_edge1_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk("lat_edge2_valid", 32'(out_valid), 32'd1);
    drain();

    send(0, 0, 7'd30, 22'h240000, 16'h4080, 0, 0);
    send(1, 0, 7'd30, 22'h240000, 16'hC080, 0, 0);
    send(0, 0, 7'd30, 22'h3FFFFF, 16'h4400, 0, 0);
    send(0, 0, 7'd30, 22'h100200, 16'h3C00, 0, 0);
    send(0, 0, 7'd30, 22'h100600, 16'h3C02, 0, 0);
    send(0, 0, 7'd60, 22'h100000, 16'h7C00, 1, 0);
    send(0, 0, 7'd10, 22'h100000, 16'h0000, 0, 1);
    send(1, 1, 7'd30, 22'h240000, 16'h8000, 0, 0);
    drain();

    out_ready = 1'b0;
    send(0, 0, 7'd30, 22'h240000, 16'h4080, 0, 0);
    begin
      int n;
      n = 0;
      while (!out_valid && n < 20) begin
        @(posedge clk); #1;
        n++;
      end
      chk("bp_reached_done", 32'(out_valid), 32'd1);
    end
    in_sign = 0; in_zero = 0; in_exp_sum = 7'd30; in_prod = 22'h100000; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_out_fp", 32'(out_fp), 32'h4080);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    send(0, 0, 7'd30, 22'h100000, 16'h3C00, 0, 0);
    drain();

    send(1, 0, 7'd30, 22'h240000, 16'hC080, 0, 0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_out_fp", 32'(out_fp), 32'd0);
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("post_rst_no_valid", 32'(out_valid), 32'd0);
    end
    send(0, 0, 7'd30, 22'h100000, 16'h3C00, 0, 0);
    drain();

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
